// File: rtl/ram8_bank.sv
// 8-word x WIDTH register bank with a demuxed write port, a combinational read port,
// per-word valid bits and an 8-cycle sequenced clear sweep.
module ram8_bank #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic [2:0]       address,
    input  logic             clr,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic [7:0]       valid_map
);

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e           state_q, state_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [WIDTH-1:0] word_q [8];
    logic [7:0]       valid_q, valid_d;
    logic [7:0]       wr_en;
    logic [7:0]       clr_en;

    // 8-way demultiplexer: routes en to the one output picked by sel.
    function automatic logic [7:0] demux8(input logic en, input logic [2:0] sel);
        logic [7:0] y;
        y      = '0;
        y[sel] = en;
        return y;
    endfunction

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wr_en   = '0;
        clr_en  = '0;
        case (state_q)
            StIdle: begin
                // A write and a clear request on the same edge both take effect.
                wr_en = demux8(load, address);
                if (clr) begin
                    state_d = StClear;
                    ptr_d   = 3'd0;
                end
            end
            StClear: begin
                clr_en = demux8(1'b1, ptr_q);
                ptr_d  = ptr_q + 3'd1;
                if (ptr_q == 3'd7) begin
                    state_d = StIdle;
                end
            end
        endcase
        valid_d = (valid_q | wr_en) & ~clr_en;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            ptr_q   <= 3'd0;
            valid_q <= 8'h00;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                word_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (wr_en[i]) begin
                    word_q[i] <= in;
                end else if (clr_en[i]) begin
                    word_q[i] <= '0;
                end
            end
        end
    end

    assign out       = word_q[address];
    assign busy      = (state_q == StClear);
    assign valid_map = valid_q;

endmodule
